serial_word_assembler: RTL
==========================

# serial_word_assembler

Upstream feeder for the parallel-load shift register stage. Collects a serially delivered data word bit by bit, optionally checks a trailing parity bit, and presents the assembled word on `load_value` with a one-cycle `load` strobe. The two outputs connect directly to the shift register's `load` and `load_value` inputs. Frames with bad parity are dropped and flagged instead of being loaded.

## Interface
- `WIDTH`, 8: data bits per frame; also the width of `load_value`. Must be at least 2.
- `BIT_ORDER`, "MSB_FIRST": "MSB_FIRST" or "LSB_FIRST"; order in which data bits arrive on `sin`.
- `PARITY`, "NONE": "NONE", "EVEN" or "ODD"; when not "NONE", one parity bit follows the data bits.
- `clk`  input  1  single clock; every register updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to begin a frame; honoured only in IDLE.
- `sin`  input  1  serial data bit.
- `sin_valid`  input  1  `sin` carries a bit this cycle.
- `load`  output  1  registered one-cycle strobe: `load_value` holds a new, good word.
- `load_value`  output  WIDTH  last good assembled word; held between strobes.
- `parity_err`  output  1  registered one-cycle strobe: frame dropped for parity mismatch.
- `busy`  output  1  high in SHIFT and PARITY states.

## Operation
- State machine has three states: IDLE, SHIFT, PARITY.
- Reset value of every output is 0: `load`, `load_value`, `parity_err`, `busy`. Internal state is IDLE, and the bit counter and shift buffer are 0.
- IDLE:
  - If `start`=1, the next state is SHIFT and the bit counter clears.
  - `sin_valid` is ignored in IDLE.
- SHIFT:
  - Each cycle with `sin_valid`=1 captures `sin` and increments the bit counter.
  - Cycles with `sin_valid`=0 hold all state. Gaps of any length are allowed.
  - MSB_FIRST: the buffer shifts left and `sin` enters bit 0. The first bit received ends up as the MSB.
  - LSB_FIRST: the buffer shifts right and `sin` enters bit WIDTH-1. The first bit received ends up as the LSB.
  - On capture of the WIDTH-th bit:
    - If `PARITY`="NONE", the next state is IDLE and the frame completes.
    - Otherwise the next state is PARITY.
- PARITY:
  - The next valid bit is the parity bit.
  - EVEN: XOR of the data bits and the parity bit must be 0.
  - ODD: that XOR must be 1.
  - On capture of the parity bit the next state is IDLE.
  - If the check passes, the frame completes.
  - If the check fails, `parity_err` is asserted for one cycle, `load` stays 0 and `load_value` is unchanged.
- Frame completion: `load_value` is written with the assembled word and `load` is set to 1 for one cycle.
- `start` asserted while `busy`=1 is ignored. It neither restarts nor queues a frame.
- Reset mid-frame: the partial frame is discarded, nothing is loaded or flagged, and all outputs return to 0 immediately (asynchronous).
- The bit counter is wide enough for the value WIDTH (clog2(WIDTH+1) bits) and clears on every start.

## Timing
- `start` sampled high in IDLE at edge N: `busy`=1 from edge N. The first bit can be captured at edge N+1.
- Latency: `load` rises at the same edge that captures the final bit (data or parity) and falls one edge later.
  - Minimum frame length from `start` to `load` is WIDTH+1 edges, or WIDTH+2 edges with parity, when `sin_valid` is high continuously.
- `busy` falls at the same edge where `load` or `parity_err` rises.
- Back-to-back frames: `start` may be high in the cycle where `load`=1, because the state is already IDLE. The new frame then starts at the next edge.
- `load` and `parity_err` are never high together, and neither lasts more than one cycle.
- `sin_valid` together with `start` in IDLE: the bit is not captured. The first bit must arrive after SHIFT is entered.

## Test plan
- WIDTH=8, MSB_FIRST, NONE: pulse `start`, then send 1,0,1,0,1,0,1,0 with `sin_valid` held high. Required: `load_value`=8'hAA and `load`=1 for exactly one cycle, 9 edges after `start`. `busy` falls at the same edge.
- Same configuration with LSB_FIRST, bits 0,1,0,1,0,1,0,1. Required: `load_value`=8'hAA. Then insert 3-cycle `sin_valid` gaps between bits of 8'h3C: `load_value`=8'h3C and there are no extra strobes.
- PARITY="EVEN", word 8'hAA:
  - Parity bit 0: `load` pulses and `load_value`=8'hAA.
  - Next frame 8'h01 with parity bit 0: `parity_err` pulses, `load` stays 0 and `load_value` remains 8'hAA.
- Assert `rst` after 4 bits of a frame: all outputs are 0 immediately. Release `rst` and send a full frame of 8'h5A: `load_value`=8'h5A, with no influence from the aborted bits.
- Pulse `start` again mid-frame while `busy`=1: ignored, and the frame completes with the originally sent word. Then assert `start` in the `load` cycle: the next frame is accepted without an idle gap.

Source files
------------

// File: rtl/serial_word_assembler.sv
// serial_word_assembler
// Assembles a serially delivered word (MSB- or LSB-first), optionally checks
// a trailing even/odd parity bit, and presents good words on load_value with a
// one-cycle load strobe. Frames with bad parity are dropped and flagged on
// parity_err instead of being loaded.
module serial_word_assembler #(
    parameter int    WIDTH     = 8,
    parameter string BIT_ORDER = "MSB_FIRST",
    parameter string PARITY    = "NONE"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             load,
    output logic [WIDTH-1:0] load_value,
    output logic             parity_err,
    output logic             busy
);

    localparam int CW         = $clog2(WIDTH + 1);
    localparam bit LSB_FIRST  = (BIT_ORDER == "LSB_FIRST");
    localparam bit HAS_PARITY = (PARITY != "NONE");
    localparam bit ODD_PARITY = (PARITY == "ODD");

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0] shbuf, shbuf_nxt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] value_nxt;
    logic             load_nxt;
    logic             perr_nxt;

    assign busy = (state != ST_IDLE);

    // Buffer contents after capturing sin in the configured bit order
    always_comb begin
        if (LSB_FIRST) begin
            shifted = {sin, shbuf[WIDTH-1:1]};
        end else begin
            shifted = {shbuf[WIDTH-2:0], sin};
        end
    end

    // Next-state, datapath and strobe decode
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shbuf_nxt   = shbuf;
        value_nxt   = load_value;
        load_nxt    = 1'b0;
        perr_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_SHIFT;
                    bit_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (sin_valid) begin
                    shbuf_nxt   = shifted;
                    bit_cnt_nxt = bit_cnt + CW'(1);
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        if (HAS_PARITY) begin
                            state_nxt = ST_PARITY;
                        end else begin
                            state_nxt = ST_IDLE;
                            load_nxt  = 1'b1;
                            value_nxt = shifted;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (sin_valid) begin
                    state_nxt = ST_IDLE;
                    if (((^shbuf) ^ sin) == ODD_PARITY) begin
                        load_nxt  = 1'b1;
                        value_nxt = shbuf;
                    end else begin
                        perr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shbuf      <= '0;
            load_value <= '0;
            load       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shbuf      <= shbuf_nxt;
            load_value <= value_nxt;
            load       <= load_nxt;
            parity_err <= perr_nxt;
        end
    end

endmodule
